// File: rtl/instruction_decode_stage_pkg.sv
// Shared decode definitions: base opcodes and the instruction format code.
package decode_pkg;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R       = 3'd0,
      FMT_I       = 3'd1,
      FMT_S       = 3'd2,
      FMT_B       = 3'd3,
      FMT_U       = 3'd4,
      FMT_J       = 3'd5,
      FMT_ILLEGAL = 3'd6
   } fmt_t;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface instruction_decode_stage_if #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
);
   import decode_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [2:0]      out_funct3;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [6:0]      out_funct7;
   logic [XLEN-1:0] out_imm;
   fmt_t            out_fmt;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
             out_rs1, out_rs2, out_funct7, out_imm, out_fmt, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
             out_rs1, out_rs2, out_funct7, out_imm, out_fmt, out_illegal
   );

endinterface

// File: rtl/instruction_decode_stage_imm_gen.sv
// Combinational format classifier and sign-extended immediate generator.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output fmt_t            fmt,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   // Every base immediate fits in 32 bits; widen by sign extension at the end.
   logic signed [31:0] raw;

   always_comb begin
      fmt     = FMT_ILLEGAL;
      illegal = 1'b0;
      raw     = '0;
      case (instr[6:0])
         OP_REG: fmt = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
            fmt = FMT_I;
            raw = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            fmt = FMT_S;
            raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            fmt = FMT_B;
            raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt = FMT_U;
            raw = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            fmt = FMT_J;
            raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: illegal = 1'b1;
      endcase
      imm = XLEN'(raw);
   end

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered RISC-V decode stage: one-entry valid/ready pipeline register with flush.
module instruction_decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   instruction_decode_stage_if.slave   bus
);

   fmt_t            dec_fmt;
   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;

   logic            valid_q;
   logic [PC_W-1:0] pc_q;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] imm_q;
   fmt_t            fmt_q;
   logic            illegal_q;
   logic            rdy;
   logic            push;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr   (bus.in_instr),
      .fmt     (dec_fmt),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   always_comb begin
      rdy  = !reset && (!valid_q || bus.out_ready);
      push = bus.in_valid && rdy;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         instr_q   <= '0;
         imm_q     <= '0;
         fmt_q     <= FMT_R;
         illegal_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (push) begin
         valid_q   <= 1'b1;
         pc_q      <= bus.in_pc;
         instr_q   <= bus.in_instr;
         imm_q     <= dec_imm;
         fmt_q     <= dec_fmt;
         illegal_q <= dec_illegal;
      end else if (valid_q && bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Fields are sliced from the registered word so nothing on the output side sees in_instr.
   always_comb begin
      bus.in_ready    = rdy;
      bus.out_valid   = valid_q;
      bus.out_pc      = pc_q;
      bus.out_opcode  = instr_q[6:0];
      bus.out_rd      = instr_q[11:7];
      bus.out_funct3  = instr_q[14:12];
      bus.out_rs1     = instr_q[19:15];
      bus.out_rs2     = instr_q[24:20];
      bus.out_funct7  = instr_q[31:25];
      bus.out_imm     = imm_q;
      bus.out_fmt     = fmt_q;
      bus.out_illegal = illegal_q;
   end

endmodule
